// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and RAM bus bundle for the data RAM port arbiter
interface ram_port_arbiter_if #(
  parameter int N             = 3,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
);
  // Requester side: slice i of each packed vector belongs to requester i
  logic [N-1:0]               REQ;
  logic [N*ADDRESS_WIDTH-1:0] REQ_ADD_RD1;
  logic [N*ADDRESS_WIDTH-1:0] REQ_ADD_RD2;
  logic [N*ADDRESS_WIDTH-1:0] REQ_ADD_WR;
  logic [N*DATA_WIDTH-1:0]    REQ_DATA_WR;
  logic [N-1:0]               REQ_ENABLE_WR;
  logic [N-1:0]               GNT;
  logic                       BUSY;
  logic [N-1:0]               STARVE;

  // RAM side
  logic [ADDRESS_WIDTH-1:0]   RAM_ADD_RD1;
  logic [ADDRESS_WIDTH-1:0]   RAM_ADD_RD2;
  logic [ADDRESS_WIDTH-1:0]   RAM_ADD_WR;
  logic [DATA_WIDTH-1:0]      RAM_DATA_WR;
  logic                       RAM_ENABLE_WR;
  // Read data is broadcast from the RAM to every requester and bypasses the arbiter
  logic [DATA_WIDTH-1:0]      RAM_DATA_RD1;
  logic [DATA_WIDTH-1:0]      RAM_DATA_RD2;

  // Environment: requesters plus the RAM itself
  modport master (
    output REQ, REQ_ADD_RD1, REQ_ADD_RD2, REQ_ADD_WR, REQ_DATA_WR, REQ_ENABLE_WR,
    output RAM_DATA_RD1, RAM_DATA_RD2,
    input  GNT, BUSY, STARVE,
    input  RAM_ADD_RD1, RAM_ADD_RD2, RAM_ADD_WR, RAM_DATA_WR, RAM_ENABLE_WR
  );

  // Arbiter
  modport slave (
    input  REQ, REQ_ADD_RD1, REQ_ADD_RD2, REQ_ADD_WR, REQ_DATA_WR, REQ_ENABLE_WR,
    output GNT, BUSY, STARVE,
    output RAM_ADD_RD1, RAM_ADD_RD2, RAM_ADD_WR, RAM_DATA_WR, RAM_ENABLE_WR
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - locking round-robin arbiter sharing one data RAM among N requesters
module ram_port_arbiter #(
  parameter int N             = 3,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int STARVE_LIMIT  = 1024,
  parameter int CNT_WIDTH     = 11
) (
  input logic              CLK,
  input logic              RST,
  ram_port_arbiter_if.slave bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]           state, state_nxt;
  logic [IDX_W-1:0]     owner, owner_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [N-1:0]         gnt, gnt_nxt;
  logic [N-1:0]         starve, starve_nxt;
  logic [CNT_WIDTH-1:0] wait_cnt     [N];
  logic [CNT_WIDTH-1:0] wait_cnt_nxt [N];

  // First set bit of mask scanning circularly upward from start
  function automatic logic [IDX_W-1:0] scan_from(input logic [N-1:0] mask, input int start);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[(start + k) % N]) r = IDX_W'((start + k) % N);
    end
    return r;
  endfunction

  // Ownership: grant from IDLE, hold while owner keeps REQ, hand over on release
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    gnt_nxt    = gnt;
    case (state)
      ST_IDLE: begin
        if (|bus.REQ) begin
          owner_nxt = scan_from(bus.REQ, int'(rr_ptr));
          gnt_nxt   = N'(1) << owner_nxt;
          state_nxt = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (!bus.REQ[owner]) begin
          rr_ptr_nxt = IDX_W'((int'(owner) + 1) % N);
          if (|bus.REQ) begin
            // The released owner's bit is already clear, so it lands last in the scan
            owner_nxt = scan_from(bus.REQ, (int'(owner) + 1) % N);
            gnt_nxt   = N'(1) << owner_nxt;
          end else begin
            gnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Wait counters: count edges spent requesting without a grant; starve follows the new count
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (!bus.REQ[i] || gnt_nxt[i]) begin
        wait_cnt_nxt[i] = '0;
      end else if (!gnt[i] && !(&wait_cnt[i])) begin
        wait_cnt_nxt[i] = wait_cnt[i] + CNT_WIDTH'(1);
      end else begin
        wait_cnt_nxt[i] = wait_cnt[i];
      end
      starve_nxt[i] = int'(wait_cnt_nxt[i]) >= STARVE_LIMIT;
    end
  end

  // State register, updated on the falling edge with synchronous reset
  always_ff @(negedge CLK) begin
    if (!RST) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      gnt    <= '0;
      starve <= '0;
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      gnt    <= gnt_nxt;
      starve <= starve_nxt;
      for (int i = 0; i < N; i++) wait_cnt[i] <= wait_cnt_nxt[i];
    end
  end

  logic [ADDRESS_WIDTH-1:0] mux_rd1, mux_rd2, mux_wr;
  logic [DATA_WIDTH-1:0]    mux_data;
  logic                     mux_en;

  // RAM mux: OR of one-hot gated slices, all zero when nobody owns the RAM
  always_comb begin
    mux_rd1  = '0;
    mux_rd2  = '0;
    mux_wr   = '0;
    mux_data = '0;
    mux_en   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        mux_rd1  = mux_rd1  | bus.REQ_ADD_RD1[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        mux_rd2  = mux_rd2  | bus.REQ_ADD_RD2[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        mux_wr   = mux_wr   | bus.REQ_ADD_WR[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        mux_data = mux_data | bus.REQ_DATA_WR[i*DATA_WIDTH +: DATA_WIDTH];
        mux_en   = mux_en   | bus.REQ_ENABLE_WR[i];
      end
    end
  end

  assign bus.GNT           = gnt;
  assign bus.BUSY          = |gnt;
  assign bus.STARVE        = starve;
  assign bus.RAM_ADD_RD1   = mux_rd1;
  assign bus.RAM_ADD_RD2   = mux_rd2;
  assign bus.RAM_ADD_WR    = mux_wr;
  assign bus.RAM_DATA_WR   = mux_data;
  assign bus.RAM_ENABLE_WR = mux_en;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
  localparam int N     = 3;
  localparam int AW    = 13;
  localparam int DW    = 64;
  localparam int LIMIT = 1024;
  localparam int CW    = 11;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk;
  logic rst;

  ram_port_arbiter_if #(.N(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  ram_port_arbiter #(
    .N(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(ifc)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the RAM, where the round-robin scan starts, wait lengths
  int m_owner = -1;
  int m_ptr   = 0;
  int m_wait [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  prev;
    bit  found;
    if (!rst) begin
      m_owner = -1;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      prev = m_owner;
      if (m_owner >= 0 && !ifc.REQ[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
      if (m_owner < 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && ifc.REQ[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            found   = 1;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!ifc.REQ[i] || m_owner == i) m_wait[i] = 0;
        else if (prev != i && m_wait[i] < CMAX) m_wait[i] = m_wait[i] + 1;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0]  eg, es;
    logic [AW-1:0] a1, a2, aw;
    logic [DW-1:0] d;
    logic          we;
    #1;
    eg = '0; es = '0; a1 = '0; a2 = '0; aw = '0; d = '0; we = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      a1 = ifc.REQ_ADD_RD1[m_owner*AW +: AW];
      a2 = ifc.REQ_ADD_RD2[m_owner*AW +: AW];
      aw = ifc.REQ_ADD_WR[m_owner*AW +: AW];
      d  = ifc.REQ_DATA_WR[m_owner*DW +: DW];
      we = ifc.REQ_ENABLE_WR[m_owner];
    end
    for (int i = 0; i < N; i++) es[i] = (m_wait[i] >= LIMIT);
    chk({tag, ".gnt"},    64'(ifc.GNT),           64'(eg));
    chk({tag, ".busy"},   64'(ifc.BUSY),          64'(m_owner >= 0));
    chk({tag, ".starve"}, 64'(ifc.STARVE),        64'(es));
    chk({tag, ".rd1"},    64'(ifc.RAM_ADD_RD1),   64'(a1));
    chk({tag, ".rd2"},    64'(ifc.RAM_ADD_RD2),   64'(a2));
    chk({tag, ".wr"},     64'(ifc.RAM_ADD_WR),    64'(aw));
    chk({tag, ".data"},   ifc.RAM_DATA_WR,        d);
    chk({tag, ".we"},     64'(ifc.RAM_ENABLE_WR), 64'(we));
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      ifc.REQ_ADD_RD1[i*AW +: AW] = AW'($urandom);
      ifc.REQ_ADD_RD2[i*AW +: AW] = AW'($urandom);
      ifc.REQ_ADD_WR[i*AW +: AW]  = AW'($urandom);
      ifc.REQ_DATA_WR[i*DW +: DW] = {$urandom, $urandom};
    end
    ifc.REQ_ENABLE_WR = N'($urandom);
  endtask

  task automatic step(input logic [N-1:0] req, input string tag);
    ifc.REQ = req;
    rand_data();
    cycle();
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0;
    ifc.REQ = '0;
    ifc.RAM_DATA_RD1 = '0;
    ifc.RAM_DATA_RD2 = '0;
    rand_data();
    cycle();
    cycle();
    check_all("reset");
    chk("reset.gnt0", 64'(ifc.GNT), 64'(0));
    rst = 1'b1;

    // Single request from requester 2, address tracking and write-enable mirroring
    ifc.REQ = 3'b100;
    rand_data();
    ifc.REQ_ADD_WR[2*AW +: AW] = AW'(5407);
    cycle();
    check_all("single");
    chk("single.gnt", 64'(ifc.GNT), 64'(3'b100));
    chk("single.addwr", 64'(ifc.RAM_ADD_WR), 64'(5407));
    ifc.REQ_ENABLE_WR = 3'b011;
    check_all("single.we0");
    chk("single.we_lo", 64'(ifc.RAM_ENABLE_WR), 64'(0));
    ifc.REQ_ENABLE_WR = 3'b100;
    check_all("single.we1");
    chk("single.we_hi", 64'(ifc.RAM_ENABLE_WR), 64'(1));
    step(3'b000, "single.rel");

    // Round-robin hand-over with no dead cycle, pointer wraps from 2 to 0
    step(3'b111, "rr0");
    chk("rr.g001", 64'(ifc.GNT), 64'(3'b001));
    step(3'b110, "rr1");
    chk("rr.g010", 64'(ifc.GNT), 64'(3'b010));
    step(3'b100, "rr2");
    chk("rr.g100", 64'(ifc.GNT), 64'(3'b100));
    step(3'b000, "rr3");
    chk("rr.g000", 64'(ifc.GNT), 64'(3'b000));
    chk("rr.busy0", 64'(ifc.BUSY), 64'(0));

    // Owner 1 writing while the others also assert write enable
    step(3'b010, "own1.grant");
    for (int k = 0; k < 6; k++) begin
      ifc.REQ = 3'b111;
      rand_data();
      ifc.REQ_ENABLE_WR = 3'b111;
      cycle();
      check_all("own1.hold");
      chk("own1.wr", 64'(ifc.RAM_ADD_WR), 64'(ifc.REQ_ADD_WR[1*AW +: AW]));
    end
    step(3'b101, "own1.handover");
    chk("own1.next", 64'(ifc.GNT), 64'(3'b100));
    step(3'b000, "own1.idle");

    // Requester 0 starves behind a long transaction of requester 2
    step(3'b100, "starve.grant2");
    for (int k = 1; k <= LIMIT + 5; k++) begin
      step(3'b101, "starve.wait");
      if (k == LIMIT - 1) chk("starve.pre", 64'(ifc.STARVE[0]), 64'(0));
      if (k == LIMIT) chk("starve.rise", 64'(ifc.STARVE[0]), 64'(1));
    end
    chk("starve.held", 64'(ifc.GNT), 64'(3'b100));
    step(3'b001, "starve.grant0");
    chk("starve.g0", 64'(ifc.GNT), 64'(3'b001));
    chk("starve.clr", 64'(ifc.STARVE), 64'(0));
    step(3'b000, "starve.idle");

    // Reset in the middle of a write by requester 1
    step(3'b010, "rst.grant1");
    ifc.REQ_ENABLE_WR = 3'b010;
    check_all("rst.write");
    rst = 1'b0;
    cycle();
    check_all("rst.edge");
    chk("rst.gnt", 64'(ifc.GNT), 64'(0));
    chk("rst.we", 64'(ifc.RAM_ENABLE_WR), 64'(0));
    rst = 1'b1;
    step(3'b011, "rst.after");
    chk("rst.ptr0", 64'(ifc.GNT), 64'(3'b001));

    // Requester 1 pulses while 0 owns and is never granted
    step(3'b001, "pulse.a");
    step(3'b011, "pulse.b");
    for (int k = 0; k < 3; k++) begin
      step(3'b001, "pulse.c");
      chk("pulse.own0", 64'(ifc.GNT), 64'(3'b001));
    end
    step(3'b000, "pulse.rel");
    chk("pulse.idle", 64'(ifc.GNT), 64'(0));

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] r;
      r = ifc.REQ;
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) r[i] = ~r[i];
      rst = ($urandom_range(63) != 0);
      step(r, "rand");
    end
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the solver's single data RAM among N requesters: host loader, interpolator and Euler engine by default.
- The RAM has two read ports and one write port.
- Each requester holds the whole RAM for a complete transaction (lock until it drops REQ). Ownership passes in round-robin order.
- The block sits between the requesters and the RAM. It muxes the owner's addresses and write data to the RAM and broadcasts read data to all requesters.

Parameters:
N, 3, number of requesters (index 0 host loader, 1 interpolator, 2 Euler)
ADDRESS_WIDTH, 13, RAM address width
DATA_WIDTH, 64, RAM data width
STARVE_LIMIT, 1024, wait cycles before STARVE flag for a requester
CNT_WIDTH, 11, width of each wait counter; must hold STARVE_LIMIT

Ports:
CLK  in  1  clock; all state updates on falling edge
RST  in  1  synchronous, active-low reset
REQ  in  N  per-requester request; held high for the whole transaction
REQ_ADD_RD1  in  N*ADDRESS_WIDTH  read-port-1 address, slice i = requester i
REQ_ADD_RD2  in  N*ADDRESS_WIDTH  read-port-2 address
REQ_ADD_WR  in  N*ADDRESS_WIDTH  write address
REQ_DATA_WR  in  N*DATA_WIDTH  write data
REQ_ENABLE_WR  in  N  write enable
GNT  out  N  one-hot (or zero) grant, registered
BUSY  out  1  high while any grant is held
STARVE  out  N  requester i has waited >= STARVE_LIMIT cycles
RAM_ADD_RD1, RAM_ADD_RD2, RAM_ADD_WR  out  ADDRESS_WIDTH each  to RAM
RAM_DATA_WR  out  DATA_WIDTH  to RAM
RAM_ENABLE_WR  out  1  to RAM
RAM_DATA_RD1, RAM_DATA_RD2  in  DATA_WIDTH each  from RAM; wired straight through to requesters outside this block

Behaviour:

Reset:
- RST==0 at a falling edge sets: GNT=0, BUSY=0, STARVE=0, rr pointer=0, all wait counters=0, state IDLE.
- All RAM outputs then read 0.

States:
- IDLE:
  - No REQ bit set: stay in IDLE.
  - Otherwise grant the first set REQ bit scanning circularly from the rr pointer, on the same edge, then go to OWNED.
- OWNED (owner o):
  - REQ[o]==1 sampled: hold GNT unchanged.
  - REQ[o]==0 sampled: release. Set rr pointer=(o+1) mod N.
  - On release with other REQ bits set: grant the next requester on the same edge, scanning from o+1. Hand-over has no dead cycle and state stays OWNED.
  - On release with no other REQ bits set: GNT=0 and state goes to IDLE.

Latency and muxing:
- Request to grant is 1 falling edge when the RAM is free.
- The RAM output mux is combinational from registered GNT and the owner's input slices, so the requester's address timing is unchanged once granted.
- No grant: all RAM addresses 0, RAM_DATA_WR 0, RAM_ENABLE_WR 0.
- REQ_ENABLE_WR of a non-owner never reaches the RAM.

Grant rules:
- GNT is always one-hot or zero. BUSY equals |GNT.
- The owner is never preempted, regardless of STARVE.

Wait counters and STARVE:
- Counter i increments on each edge with REQ[i]=1 and GNT[i]=0, saturating at all-ones.
- Counter i clears when requester i is granted or drops REQ.
- STARVE[i] is registered high while counter i >= STARVE_LIMIT. It is informational only.

Boundary conditions:
- A requester withdrawing REQ before grant is skipped with no grant.
- Owner dropping REQ for a single cycle and re-raising it is a release plus a new request. It re-enters at the lowest round-robin priority.
- Reset mid-transaction drops GNT on that edge, which forces RAM_ENABLE_WR low immediately after the edge.
- N=1 degenerates to grant-on-request with a 1-cycle release.
- Pointer wrap: o=N-1 → pointer 0.

Test Plan:
- Reset, then REQ=3'b100 → GNT=3'b100 after 1 falling edge. RAM_ADD_WR follows requester 2's slice (e.g. 5407). RAM_ENABLE_WR mirrors REQ_ENABLE_WR[2].
- REQ=3'b111 from IDLE with pointer 0 → GNT 001. Owner drops REQ → next edge GNT 010 with no zero cycle. Drop again → 100. Drop again → 000, BUSY=0.
- Owner 1 holds with write enable high while REQ_ENABLE_WR[0]=REQ_ENABLE_WR[2]=1 and different addresses → RAM sees only requester 1's address/data for every cycle of ownership.
- Requester 0 waits while requester 2 holds for STARVE_LIMIT+5 cycles → STARVE[0] rises after 1024 waiting edges. Grant remains with 2 until its release. STARVE[0] clears on the edge granting 0.
- RST=0 asserted mid-write with GNT=010 → next edge GNT=000, RAM_ENABLE_WR=0, STARVE=0. After RST=1 with REQ=011 → GNT=001 (pointer back to 0).
- Requester 1 pulses REQ for 1 cycle while 0 owns, then drops it → 1 never granted. Release by 0 with no other requests → IDLE, GNT=000.
